// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared types and constants for the DLX load-use / freeze
//           controller: FSM state encoding, register-zero constant and
//           the per-cycle pipeline control word.
// Rev     : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // FSM states: RUN = normal issue, LSTALL = extra load-use bubbles pending
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } state_t;

  // Architectural zero register; never a real producer
  localparam int REG_ZERO = 0;

  // Pipeline control word, MSB first
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic mux_ctrl;
    logic ifid_flush;
  } ctrl_t;

  // Bit positions of the control word when handled as a plain vector
  localparam int CTRL_PC_WRITE_BIT   = 4;
  localparam int CTRL_IFID_WRITE_BIT = 3;
  localparam int CTRL_IDEX_WRITE_BIT = 2;
  localparam int CTRL_MUX_CTRL_BIT   = 1;
  localparam int CTRL_IFID_FLUSH_BIT = 0;

  // Canonical control words
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                    mux_ctrl: 1'b0, ifid_flush: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1,
                                    mux_ctrl: 1'b1, ifid_flush: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                    mux_ctrl: 1'b0, ifid_flush: 1'b0};

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_if
// Brief   : Bundle between the ID stage and the hazard controller: operand
//           / producer compare inputs, branch and memory status in, pipeline
//           enables and statistics out.
// Rev     : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] IFID_rs;
  logic [REG_AW-1:0] IFID_rt;
  logic              IFID_use_rs;
  logic              IFID_use_rt;
  logic [REG_AW-1:0] IDEX_rt;
  logic              IDEX_MemRead;
  logic              branch_taken;
  logic              mem_busy;

  logic              PC_write;
  logic              IFID_write;
  logic              IDEX_write;
  logic              mux_ctrl;
  logic              IFID_flush;
  logic              stall_active;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  freeze_cycles;

  // Pipeline side
  modport master (
    output IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt,
           IDEX_rt, IDEX_MemRead, branch_taken, mem_busy,
    input  PC_write, IFID_write, IDEX_write, mux_ctrl, IFID_flush,
           stall_active, stall_cycles, freeze_cycles
  );

  // Hazard controller side
  modport slave (
    input  IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt,
           IDEX_rt, IDEX_MemRead, branch_taken, mem_busy,
    output PC_write, IFID_write, IDEX_write, mux_ctrl, IFID_flush,
           stall_active, stall_cycles, freeze_cycles
  );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones; asynchronous active-low clear.
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  output logic [WIDTH-1:0]      count
);

  logic [WIDTH-1:0] r_count;

  // Count qualifying cycles, holding once the maximum is reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Load-use stall / memory-freeze / branch-flush controller for the
//           5-stage DLX pipeline. Priority each cycle: freeze > stall >
//           flush > run. A hazard stalls in the same cycle; LOAD_LAT-1
//           further bubbles come from the LSTALL state.
//           Optional macro HAZARD_STATS_EN adds saturating stall / freeze
//           cycle counters; without it both count ports read zero.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  hazard_ctrl_if.slave bus
);

  // Bubbles still owed after the hazard cycle itself
  localparam logic [3:0] c_cnt_init = 4'(LOAD_LAT - 1);
  localparam bit         c_multi    = (LOAD_LAT > 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_match_rs;
  logic       w_match_rt;
  logic       w_hazard;
  ctrl_t      w_ctrl;

  assign w_match_rs = bus.IFID_use_rs && (bus.IDEX_rt == bus.IFID_rs);
  assign w_match_rt = bus.IFID_use_rt && (bus.IDEX_rt == bus.IFID_rt);
  assign w_hazard   = bus.IDEX_MemRead && (w_match_rs || w_match_rt)
                      && (bus.IDEX_rt != REG_AW'(REG_ZERO));

  // Control decode; reset forces the free-running word, and a stalled
  // ID ignores its own branch outcome
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (!rst) begin
      w_ctrl = CTRL_RUN;
    end else if (bus.mem_busy) begin
      w_ctrl = CTRL_FREEZE;
    end else if ((r_state == LSTALL) || w_hazard) begin
      w_ctrl = CTRL_STALL;
    end else begin
      w_ctrl.ifid_flush = bus.branch_taken;
    end
  end

  // Stall FSM; a freeze holds both state and remaining bubble count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else if (!bus.mem_busy) begin
      case (r_state)
        RUN: begin
          if (w_hazard && c_multi) begin
            r_state <= LSTALL;
            r_cnt   <= c_cnt_init;
          end
        end
        LSTALL: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.PC_write     = w_ctrl.pc_write;
  assign bus.IFID_write   = w_ctrl.ifid_write;
  assign bus.IDEX_write   = w_ctrl.idex_write;
  assign bus.mux_ctrl     = w_ctrl.mux_ctrl;
  assign bus.IFID_flush   = w_ctrl.ifid_flush;
  assign bus.stall_active = (r_state == LSTALL);

`ifdef HAZARD_STATS_EN
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_ctrl.mux_ctrl),
    .count (bus.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.mem_busy),
    .count (bus.freeze_cycles)
  );
`else
  assign bus.stall_cycles  = CNT_W'(0);
  assign bus.freeze_cycles = CNT_W'(0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Self-checking bench for hazard_ctrl. Three instances share one
//           stimulus stream: LOAD_LAT=1 (index 0), 3 (index 1), 4 (index 2).
//           Expected control words are queued as stimulus is applied and
//           compared when the cycle's outputs are sampled.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;
  import hazard_pkg::*;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] s_rs, s_rt, s_idex_rt;
  logic       s_use_rs, s_use_rt, s_mr, s_br, s_busy;

  // {PC_write, IFID_write, IDEX_write, mux_ctrl, IFID_flush, stall_active}
  logic [5:0]  act        [3];
  logic [15:0] stall_cnt  [3];
  logic [15:0] freeze_cnt [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    logic [5:0] exp;
    string      tag;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic       br;
    logic       busy;
    logic [5:0] exp;
  } step_t;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
      assign bus.IFID_rs      = s_rs;
      assign bus.IFID_rt      = s_rt;
      assign bus.IFID_use_rs  = s_use_rs;
      assign bus.IFID_use_rt  = s_use_rt;
      assign bus.IDEX_rt      = s_idex_rt;
      assign bus.IDEX_MemRead = s_mr;
      assign bus.branch_taken = s_br;
      assign bus.mem_busy     = s_busy;
      hazard_ctrl #(.REG_AW(5), .LOAD_LAT(LAT), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
      assign act[g]        = {bus.PC_write, bus.IFID_write, bus.IDEX_write,
                              bus.mux_ctrl, bus.IFID_flush, bus.stall_active};
      assign stall_cnt[g]  = bus.stall_cycles;
      assign freeze_cnt[g] = bus.freeze_cycles;
    end
  endgenerate

  task automatic set_inputs(input step_t s);
    s_idex_rt = s.idex_rt;
    s_rs      = s.rs;
    s_rt      = s.rt;
    s_use_rs  = s.urs;
    s_use_rt  = s.urt;
    s_mr      = s.mr;
    s_br      = s.br;
    s_busy    = s.busy;
  endtask

  // Apply one cycle of stimulus just after the edge and queue its expectation
  task automatic drive(input step_t s, input int dut, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    set_inputs(s);
    e.dut = dut;
    e.exp = s.exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_inputs('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    set_inputs('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      e.dut = d; e.exp = 6'b111000; e.tag = "reset_ctrl";
      sb.push_back(e);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s dut%0d: got %b want %b", e.tag, e.dut, act[e.dut], e.exp);
      end
      checks++;
      if ({stall_cnt[d], freeze_cnt[d]} !== 32'd0) begin
        errors++;
        $display("FAIL reset_cnt dut%0d: got %0d/%0d want 0/0", d, stall_cnt[d], freeze_cnt[d]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_load_use_lat1();
    exp_t e;
    step_t t[2];
    t[0] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100};
    t[1] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(t[i], 0, "lat1");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s step%0d: got %b want %b", e.tag, i, act[e.dut], e.exp);
      end
    end
    checks++;
    if (stall_cnt[0] !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL lat1_stall_cnt: got %0d want %0d", stall_cnt[0], STATS ? 1 : 0);
    end
  endtask

  task automatic test_r0_and_use();
    exp_t e;
    step_t t[4];
    t[0] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b111000};
    t[1] = '{5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111000};
    t[2] = '{5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100};
    t[3] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(t[i], 0, "r0_use");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s step%0d: got %b want %b", e.tag, i, act[e.dut], e.exp);
      end
    end
  endtask

  task automatic test_multi_stall();
    exp_t e;
    step_t t[4];
    t[0] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100};
    t[1] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001101};
    t[2] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001101};
    t[3] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(t[i], 1, "lat3");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s step%0d: got %b want %b", e.tag, i, act[e.dut], e.exp);
      end
    end
    checks++;
    if (stall_cnt[1] !== (STATS ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL lat3_stall_cnt: got %0d want %0d", stall_cnt[1], STATS ? 3 : 0);
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    step_t t[6];
    t[0] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100};
    t[1] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001};
    t[2] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001};
    t[3] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001101};
    t[4] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001101};
    t[5] = '{5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(t[i], 1, "freeze");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s step%0d: got %b want %b", e.tag, i, act[e.dut], e.exp);
      end
    end
    checks++;
    if (stall_cnt[1] !== (STATS ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL freeze_stall_cnt: got %0d want %0d", stall_cnt[1], STATS ? 3 : 0);
    end
    checks++;
    if (freeze_cnt[1] !== (STATS ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL freeze_cnt: got %0d want %0d", freeze_cnt[1], STATS ? 2 : 0);
    end
  endtask

  task automatic test_branch_flush();
    exp_t e;
    step_t t[4];
    t[0] = '{5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b111010};
    t[1] = '{5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    t[2] = '{5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b001100};
    t[3] = '{5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(t[i], 0, "branch");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s step%0d: got %b want %b", e.tag, i, act[e.dut], e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    step_t t[5];
    t[0] = '{5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100};
    t[1] = '{5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001101};
    t[2] = '{5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111000};
    t[3] = t[2];
    t[4] = t[2];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(t[i], 2, "lat4_pre");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s step%0d: got %b want %b", e.tag, i, act[e.dut], e.exp);
      end
    end
    // Asynchronous reset while bubbles are still owed
    rst = 1'b0;
    #1;
    e.dut = 2; e.exp = 6'b111000; e.tag = "midreset_ctrl";
    sb.push_back(e);
    e = sb.pop_front();
    checks++;
    if (act[e.dut] !== e.exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.tag, act[e.dut], e.exp);
    end
    checks++;
    if ({stall_cnt[2], freeze_cnt[2]} !== 32'd0) begin
      errors++;
      $display("FAIL midreset_cnt: got %0d/%0d want 0/0", stall_cnt[2], freeze_cnt[2]);
    end
    #1;
    rst = 1'b1;
    for (int i = 2; i < 5; i++) begin
      drive(t[i], 2, "lat4_post");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL %s step%0d: got %b want %b", e.tag, i, act[e.dut], e.exp);
      end
    end
    checks++;
    if (stall_cnt[2] !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_stall_cnt: got %0d want 0", stall_cnt[2]);
    end
  endtask

  initial begin
    set_inputs('0);
    test_reset();
    test_load_use_lat1();
    test_r0_and_use();
    test_multi_stall();
    test_freeze();
    test_branch_flush();
    test_reset_mid_stall();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised load-use / pipeline-freeze controller for the 5-stage DLX pipeline. Sits beside the ID stage and drives the PC, IF/ID and ID/EX write enables, the ID/EX bubble mux and the IF/ID flush.
- Replaces the single-cycle combinational load-use detector. Adds:
  - configurable register-address width and load-to-use latency (multi-cycle stall FSM)
  - r0 exclusion
  - per-operand use qualifiers
  - memory-busy pipeline freeze
  - taken-branch flush
  - optional stall statistics

Parameters:
- REG_AW, 5, register-address width in bits.
- LOAD_LAT, 1, number of bubble cycles per load-use hazard (1..15).
- CNT_W, 16, stall-counter width (used only with HAZARD_STATS_EN).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- IFID_rs  in  REG_AW  source register 1 of the instruction in ID.
- IFID_rt  in  REG_AW  source register 2 of the instruction in ID.
- IFID_use_rs  in  1  ID instruction reads rs.
- IFID_use_rt  in  1  ID instruction reads rt.
- IDEX_rt  in  REG_AW  destination of the instruction in EX.
- IDEX_MemRead  in  1  EX instruction is a load.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- PC_write  out  1  PC load enable.
- IFID_write  out  1  IF/ID load enable.
- IDEX_write  out  1  ID/EX load enable.
- mux_ctrl  out  1  1 = inject bubble (zero control) into ID/EX.
- IFID_flush  out  1  clear IF/ID to NOP.
- stall_active  out  1  FSM is in LSTALL.
- stall_cycles  out  CNT_W  saturating count of bubble cycles.
- freeze_cycles  out  CNT_W  saturating count of freeze cycles.

Behaviour:
- hazard = IDEX_MemRead & ((IFID_use_rs & IDEX_rt==IFID_rs) | (IFID_use_rt & IDEX_rt==IFID_rt)) & (IDEX_rt != 0). Register 0 never causes a hazard.
- FSM states: RUN, LSTALL. Down-counter cnt is 4 bits wide.
- Reset (rst=0, async):
  - state=RUN, cnt=0, both counters 0.
  - Outputs: PC_write=1, IFID_write=1, IDEX_write=1, mux_ctrl=0, IFID_flush=0, stall_active=0.
- Priority per cycle: freeze > stall > flush > run.
- Freeze (mem_busy=1, any state):
  - PC_write=0, IFID_write=0, IDEX_write=0, mux_ctrl=0, IFID_flush=0.
  - FSM state and cnt hold.
  - freeze_cycles increments.
- RUN, no hazard:
  - All write enables 1, mux_ctrl=0.
  - IFID_flush=branch_taken.
- RUN, hazard (combinational, zero latency, same cycle):
  - PC_write=0, IFID_write=0, IDEX_write=1, mux_ctrl=1, IFID_flush=0. A branch in a stalled ID is ignored.
  - If LOAD_LAT>1: next state=LSTALL, cnt=LOAD_LAT-1.
  - If LOAD_LAT==1: stay in RUN.
- LSTALL:
  - Outputs as for RUN-hazard, regardless of current compare inputs. The load has left EX.
  - stall_active=1.
  - cnt decrements each non-frozen cycle; when cnt==1 and not frozen, next state=RUN.
- Total bubbles per hazard = LOAD_LAT exactly, independent of intervening freeze cycles.
- stall_cycles increments on every cycle with mux_ctrl=1.
- Both counters saturate at all-ones.
- Async reset mid-LSTALL returns to RUN immediately; any pending bubbles are discarded.

Optional Feature:
- HAZARD_STATS_EN defined: stall_cycles and freeze_cycles counters are implemented as described.
- Not defined: the counter registers are removed, both ports are tied to 0, and CNT_W is unused.
- Control behaviour is identical in both builds.

Decomposition:
- Package hazard_pkg: state enum (RUN, LSTALL), constant REG_ZERO, and the control-output struct/bit positions (PC_write, IFID_write, IDEX_write, mux_ctrl, IFID_flush).
- Sub-module sat_counter (parametric width, inc, async active-low clear), instantiated twice and only under HAZARD_STATS_EN.

Test Plan:
1. Reset, LOAD_LAT=1: IDEX_MemRead=1, IDEX_rt=3, IFID_rs=3, use_rs=1 → same cycle PC_write=0, IFID_write=0, mux_ctrl=1; next cycle (MemRead=0) all enables 1, stall_cycles=1.
2. r0 and use qualifiers: IDEX_rt=0=IFID_rs with MemRead=1 → no stall. Then IDEX_rt=5=IFID_rt, use_rt=0 → no stall.
3. LOAD_LAT=3, hazard once → exactly 3 consecutive cycles of mux_ctrl=1, stall_active=1 during cycles 2-3, then RUN; stall_cycles=3.
4. LOAD_LAT=3, mem_busy=1 for 2 cycles during the 2nd bubble → all write enables 0, mux_ctrl=0 for those cycles; still 3 bubbles total; freeze_cycles=2.
5. branch_taken=1 with no hazard → IFID_flush=1 for one cycle. branch_taken=1 together with a hazard → IFID_flush=0, stall asserted.
6. Assert rst low mid-LSTALL (LOAD_LAT=4, after 1 bubble) → outputs immediately return to reset values, counters 0; after release, no residual bubbles.
